apb_fsm_controller: RTL and testbench

Sequences APB transfers for the AHB-to-APB bridge. Accepts qualified AHB requests from the bridge's AHB slave interface (valid, tempselx, address/data), runs each one as an APB SETUP then ENABLE phase, and stalls the AHB master through Hreadyout. One outstanding transfer at a time. Hreadyout feeds back as the slave interface's Hreadyin.

---
 rtl/apb_fsm_controller_if.sv | 38 +++
 rtl/apb_fsm_controller.sv | 127 ++++++++++++
 tb/tb_apb_fsm_controller.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_fsm_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : apb_fsm_controller_if
//  Description : Bus bundle between the AHB slave interface, the APB
//                sequencing controller and the APB peripherals.
//                AHB side : valid, Hwrite, Haddr, Hwdata, tempselx, Hreadyout
//                APB side : Pselx, Penable, Pwrite, Paddr, Pwdata
//                modport slave  - the controller (drives Hreadyout and APB)
//                modport master - the requester / environment
//  Revision    : 1.0 - initial release
// ============================================================================
interface apb_fsm_controller_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  valid;
    logic                  Hwrite;
    logic [ADDR_WIDTH-1:0] Haddr;
    logic [DATA_WIDTH-1:0] Hwdata;
    logic [2:0]            tempselx;
    logic                  Hreadyout;
    logic [2:0]            Pselx;
    logic                  Penable;
    logic                  Pwrite;
    logic [ADDR_WIDTH-1:0] Paddr;
    logic [DATA_WIDTH-1:0] Pwdata;

    modport slave (
        input  valid, Hwrite, Haddr, Hwdata, tempselx,
        output Hreadyout, Pselx, Penable, Pwrite, Paddr, Pwdata
    );

    modport master (
        output valid, Hwrite, Haddr, Hwdata, tempselx,
        input  Hreadyout, Pselx, Penable, Pwrite, Paddr, Pwdata
    );
endinterface
`default_nettype wire

// File: rtl/apb_fsm_controller.sv
`default_nettype none
// ============================================================================
//  Module      : apb_fsm_controller
//  Description : Runs each qualified AHB request as an APB SETUP + ENABLE
//                pair, one transfer at a time, stalling the AHB master via
//                Hreadyout. Writes insert one wait cycle so that Hwdata (AHB
//                data phase) can be captured before the APB SETUP phase.
//  Ports       : Hclk    - bridge clock, rising edge
//                Hresetn - asynchronous active-low reset
//                bus     - apb_fsm_controller_if.slave (AHB request in,
//                          Hreadyout and APB signals out)
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_fsm_controller #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  wire logic              Hclk,
    input  wire logic              Hresetn,
    apb_fsm_controller_if.slave    bus
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_RENABLE = 3'd2,
        ST_WWAIT   = 3'd3,
        ST_WRITE   = 3'd4,
        ST_WENABLE = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  w_accept;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [2:0]            r_sel;
    logic                  r_wr;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Capture registers. Address/select/direction are taken only on an
    // accept and then held for the whole transfer, independent of whatever
    // the AHB master puts on the address bus while it is stalled. Write
    // data arrives one cycle later (AHB data phase), hence the WWAIT load.
    // ------------------------------------------------------------------
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_sel   <= 3'b000;
            r_wr    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr <= bus.Haddr;
                r_sel  <= bus.tempselx;
                r_wr   <= bus.Hwrite;
            end
            if (r_state == ST_WWAIT) begin
                r_wdata <= bus.Hwdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs. Outputs depend only on the state and capture
    // registers, so there is no combinational path from the AHB inputs to
    // the APB side or to Hreadyout.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_accept      = 1'b0;
        bus.Hreadyout = 1'b0;
        bus.Pselx     = 3'b000;
        bus.Penable   = 1'b0;
        bus.Pwrite    = 1'b0;
        bus.Paddr     = r_addr;
        bus.Pwdata    = r_wdata;

        unique case (r_state)
            // The three ready states share the same accept/dispatch logic;
            // this is what gives back-to-back transfers without an IDLE gap.
            ST_IDLE, ST_RENABLE, ST_WENABLE: begin
                bus.Hreadyout = 1'b1;
                w_accept      = bus.valid;
                if (bus.valid) begin
                    w_state_next = bus.Hwrite ? ST_WWAIT : ST_READ;
                end else begin
                    w_state_next = ST_IDLE;
                end
                if (r_state != ST_IDLE) begin
                    bus.Pselx   = r_sel;
                    bus.Penable = 1'b1;
                    bus.Pwrite  = (r_state == ST_WENABLE) && r_wr;
                end
            end
            ST_READ: begin
                bus.Pselx    = r_sel;
                w_state_next = ST_RENABLE;
            end
            ST_WWAIT: begin
                w_state_next = ST_WRITE;
            end
            ST_WRITE: begin
                bus.Pselx    = r_sel;
                bus.Pwrite   = r_wr;
                w_state_next = ST_WENABLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_fsm_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_fsm_controller
//  Description : Self-checking bench for apb_fsm_controller. Directed
//                scenarios plus a randomized run checked against a
//                transaction-level expectation schedule.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_fsm_controller;

    logic Hclk;
    logic Hresetn;

    apb_fsm_controller_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    apb_fsm_controller #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .Hclk    (Hclk),
        .Hresetn (Hresetn),
        .bus     (bus)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected visible behaviour for one cycle of a transfer.
    typedef struct packed {
        logic       ready;
        logic [2:0] sel;
        logic       pen;
        logic       pwr;
        logic       wwait;   // Hwdata driven in this cycle becomes Pwdata
    } exp_t;

    localparam exp_t IDLE_E = '{ready: 1'b1, sel: 3'b000, pen: 1'b0, pwr: 1'b0, wwait: 1'b0};

    exp_t        exp_q[$];
    exp_t        cur;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;

    task automatic model_reset();
        exp_q.delete();
        cur     = IDLE_E;
        m_addr  = 32'h0;
        m_wdata = 32'h0;
    endtask

    // Drive one cycle of AHB inputs (from a negedge), advance to the next
    // negedge, and update the expectation schedule. A read contributes a
    // SETUP and an ENABLE cycle; a write contributes a wait, SETUP, ENABLE.
    task automatic drive_cycle(input logic v, input logic w, input logic [31:0] a,
                               input logic [31:0] d, input logic [2:0] s);
        logic acc;
        logic ww;
        bus.valid    = v;
        bus.Hwrite   = w;
        bus.Haddr    = a;
        bus.Hwdata   = d;
        bus.tempselx = s;
        acc = cur.ready && v;
        ww  = cur.wwait;
        @(posedge Hclk);
        @(negedge Hclk);
        if (ww) m_wdata = d;
        if (acc) begin
            m_addr = a;
            if (w) begin
                exp_q.push_back('{ready: 1'b0, sel: 3'b000, pen: 1'b0, pwr: 1'b0, wwait: 1'b1});
                exp_q.push_back('{ready: 1'b0, sel: s,      pen: 1'b0, pwr: 1'b1, wwait: 1'b0});
                exp_q.push_back('{ready: 1'b1, sel: s,      pen: 1'b1, pwr: 1'b1, wwait: 1'b0});
            end else begin
                exp_q.push_back('{ready: 1'b0, sel: s,      pen: 1'b0, pwr: 1'b0, wwait: 1'b0});
                exp_q.push_back('{ready: 1'b1, sel: s,      pen: 1'b1, pwr: 1'b0, wwait: 1'b0});
            end
        end
        cur = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE_E;
    endtask

    task automatic idle_cycle();
        drive_cycle(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    endtask

    // Drop reset asynchronously between clock edges.
    task automatic assert_reset();
        #2 Hresetn = 1'b0;
        #1;
        bus.valid = 1'b0;
        model_reset();
    endtask

    task automatic release_reset();
        @(negedge Hclk);
        Hresetn = 1'b1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        n_checks++;
        if ({bus.Hreadyout, bus.Pselx, bus.Penable, bus.Pwrite} !== 6'b1_000_0_0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 100000",
                     {bus.Hreadyout, bus.Pselx, bus.Penable, bus.Pwrite});
        end
        n_checks++;
        if ({bus.Paddr, bus.Pwdata} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_data: got Paddr=%h Pwdata=%h want 0", bus.Paddr, bus.Pwdata);
        end
    endtask

    task automatic test_single_read();
        drive_cycle(1'b1, 1'b0, 32'h8000_0010, 32'h0, 3'b001);
        n_checks++;
        if ({bus.Hreadyout, bus.Pselx, bus.Penable, bus.Pwrite} !== 6'b0_001_0_0 ||
            bus.Paddr !== 32'h8000_0010) begin
            n_fail++;
            $display("FAIL read_setup: got ctrl=%b Paddr=%h want 000100 80000010",
                     {bus.Hreadyout, bus.Pselx, bus.Penable, bus.Pwrite}, bus.Paddr);
        end
        idle_cycle();
        n_checks++;
        if ({bus.Hreadyout, bus.Pselx, bus.Penable, bus.Pwrite} !== 6'b1_001_1_0) begin
            n_fail++;
            $display("FAIL read_enable: got %b want 100110",
                     {bus.Hreadyout, bus.Pselx, bus.Penable, bus.Pwrite});
        end
        idle_cycle();
        n_checks++;
        if ({bus.Hreadyout, bus.Pselx, bus.Penable} !== 5'b1_000_0) begin
            n_fail++;
            $display("FAIL read_done: got %b want 10000",
                     {bus.Hreadyout, bus.Pselx, bus.Penable});
        end
    endtask

    task automatic test_single_write();
        drive_cycle(1'b1, 1'b1, 32'h8400_0020, 32'h0, 3'b010);
        n_checks++;
        if ({bus.Hreadyout, bus.Pselx, bus.Penable} !== 5'b0_000_0) begin
            n_fail++;
            $display("FAIL write_wait: got %b want 00000",
                     {bus.Hreadyout, bus.Pselx, bus.Penable});
        end
        drive_cycle(1'b0, 1'b0, 32'h0, 32'hDEAD_BEEF, 3'b000);
        n_checks++;
        if ({bus.Hreadyout, bus.Pselx, bus.Penable, bus.Pwrite} !== 6'b0_010_0_1 ||
            bus.Pwdata !== 32'hDEAD_BEEF || bus.Paddr !== 32'h8400_0020) begin
            n_fail++;
            $display("FAIL write_setup: got ctrl=%b Paddr=%h Pwdata=%h want 001001 84000020 deadbeef",
                     {bus.Hreadyout, bus.Pselx, bus.Penable, bus.Pwrite}, bus.Paddr, bus.Pwdata);
        end
        idle_cycle();
        n_checks++;
        if ({bus.Hreadyout, bus.Pselx, bus.Penable, bus.Pwrite} !== 6'b1_010_1_1) begin
            n_fail++;
            $display("FAIL write_enable: got %b want 101011",
                     {bus.Hreadyout, bus.Pselx, bus.Penable, bus.Pwrite});
        end
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        drive_cycle(1'b1, 1'b0, 32'h8000_0000, 32'h0, 3'b001);
        idle_cycle();   // now in read ENABLE
        drive_cycle(1'b1, 1'b1, 32'h8800_0004, 32'h0, 3'b100);
        n_checks++;
        if ({bus.Hreadyout, bus.Pselx, bus.Penable} !== 5'b0_000_0) begin
            n_fail++;
            $display("FAIL b2b_wait: got %b want 00000", {bus.Hreadyout, bus.Pselx, bus.Penable});
        end
        drive_cycle(1'b0, 1'b0, 32'h0, 32'h1234_5678, 3'b000);
        idle_cycle();
        n_checks++;
        if ({bus.Hreadyout, bus.Pselx, bus.Penable, bus.Pwrite} !== 6'b1_100_1_1 ||
            bus.Paddr !== 32'h8800_0004 || bus.Pwdata !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL b2b_write_enable: got ctrl=%b Paddr=%h Pwdata=%h want 110011 88000004 12345678",
                     {bus.Hreadyout, bus.Pselx, bus.Penable, bus.Pwrite}, bus.Paddr, bus.Pwdata);
        end
        idle_cycle();
    endtask

    task automatic test_stall_masking();
        drive_cycle(1'b1, 1'b0, 32'h8000_0100, 32'h0, 3'b010);
        drive_cycle(1'b1, 1'b1, 32'h8C00_0000, 32'h0, 3'b100);  // during READ
        n_checks++;
        if ({bus.Penable, bus.Pselx} !== 4'b1_010 || bus.Paddr !== 32'h8000_0100) begin
            n_fail++;
            $display("FAIL stall_read: got Penable/Pselx=%b Paddr=%h want 1010 80000100",
                     {bus.Penable, bus.Pselx}, bus.Paddr);
        end
        idle_cycle();
        drive_cycle(1'b1, 1'b1, 32'h8400_0200, 32'h0, 3'b001);
        drive_cycle(1'b1, 1'b0, 32'h8FFF_FFF0, 32'hCAFE_0001, 3'b100);  // during WWAIT
        drive_cycle(1'b1, 1'b0, 32'h8EEE_EEE0, 32'h0BAD_0BAD, 3'b010);  // during WRITE
        n_checks++;
        if ({bus.Hreadyout, bus.Pselx, bus.Penable, bus.Pwrite} !== 6'b1_001_1_1 ||
            bus.Paddr !== 32'h8400_0200 || bus.Pwdata !== 32'hCAFE_0001) begin
            n_fail++;
            $display("FAIL stall_write: got ctrl=%b Paddr=%h Pwdata=%h want 100111 84000200 cafe0001",
                     {bus.Hreadyout, bus.Pselx, bus.Penable, bus.Pwrite}, bus.Paddr, bus.Pwdata);
        end
        idle_cycle();
        n_checks++;
        if ({bus.Hreadyout, bus.Pselx, bus.Penable} !== 5'b1_000_0) begin
            n_fail++;
            $display("FAIL stall_no_extra: got %b want 10000", {bus.Hreadyout, bus.Pselx, bus.Penable});
        end
    endtask

    task automatic test_reset_mid_write();
        drive_cycle(1'b1, 1'b1, 32'h8400_0040, 32'h0, 3'b010);
        drive_cycle(1'b0, 1'b0, 32'h0, 32'hA5A5_5A5A, 3'b000);  // now in WRITE
        assert_reset();
        n_checks++;
        if ({bus.Hreadyout, bus.Pselx, bus.Penable, bus.Pwrite} !== 6'b1_000_0_0 ||
            bus.Paddr !== 32'h0 || bus.Pwdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_write: got ctrl=%b Paddr=%h Pwdata=%h want 100000 0 0",
                     {bus.Hreadyout, bus.Pselx, bus.Penable, bus.Pwrite}, bus.Paddr, bus.Pwdata);
        end
        release_reset();
        drive_cycle(1'b1, 1'b0, 32'h8000_0044, 32'h0, 3'b100);
        n_checks++;
        if ({bus.Hreadyout, bus.Pselx, bus.Penable, bus.Pwrite} !== 6'b0_100_0_0 ||
            bus.Paddr !== 32'h8000_0044) begin
            n_fail++;
            $display("FAIL post_reset_read: got ctrl=%b Paddr=%h want 010000 80000044",
                     {bus.Hreadyout, bus.Pselx, bus.Penable, bus.Pwrite}, bus.Paddr);
        end
        idle_cycle();
        idle_cycle();
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1'b0, $urandom_range(0, 1), $urandom, $urandom, 3'($urandom_range(0, 7)));
            n_checks++;
            if ({bus.Hreadyout, bus.Pselx, bus.Penable} !== 5'b1_000_0) begin
                n_fail++;
                $display("FAIL idle[%0d]: got %b want 10000", i, {bus.Hreadyout, bus.Pselx, bus.Penable});
            end
        end
    endtask

    task automatic test_random();
        logic [2:0] s;
        int         r;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 7);
            s = (r < 7) ? (3'b001 << (r % 3)) : 3'b000;
            drive_cycle($urandom_range(0, 2) != 0, $urandom_range(0, 1), $urandom, $urandom, s);
            n_checks++;
            if ({bus.Hreadyout, bus.Pselx, bus.Penable, bus.Pwrite} !==
                {cur.ready, cur.sel, cur.pen, cur.pwr}) begin
                n_fail++;
                $display("FAIL rand_ctrl[%0d]: got %b want %b", i,
                         {bus.Hreadyout, bus.Pselx, bus.Penable, bus.Pwrite},
                         {cur.ready, cur.sel, cur.pen, cur.pwr});
            end
            n_checks++;
            if (bus.Paddr !== m_addr) begin
                n_fail++;
                $display("FAIL rand_paddr[%0d]: got %h want %h", i, bus.Paddr, m_addr);
            end
            n_checks++;
            if (bus.Pwdata !== m_wdata) begin
                n_fail++;
                $display("FAIL rand_pwdata[%0d]: got %h want %h", i, bus.Pwdata, m_wdata);
            end
            if ($urandom_range(0, 59) == 0) begin
                assert_reset();
                n_checks++;
                if ({bus.Hreadyout, bus.Pselx, bus.Penable, bus.Pwrite, bus.Paddr, bus.Pwdata} !==
                    {6'b1_000_0_0, 64'h0}) begin
                    n_fail++;
                    $display("FAIL rand_reset[%0d]: got ctrl=%b Paddr=%h Pwdata=%h want 100000 0 0", i,
                             {bus.Hreadyout, bus.Pselx, bus.Penable, bus.Pwrite}, bus.Paddr, bus.Pwdata);
                end
                release_reset();
            end
        end
    endtask

    // ------------------------------------------------------------------
    initial begin
        Hresetn      = 1'b0;
        bus.valid    = 1'b0;
        bus.Hwrite   = 1'b0;
        bus.Haddr    = 32'h0;
        bus.Hwdata   = 32'h0;
        bus.tempselx = 3'b000;
        model_reset();
        repeat (2) @(negedge Hclk);
        test_reset();
        Hresetn = 1'b1;
        test_single_read();
        test_single_write();
        test_back_to_back();
        test_stall_masking();
        test_reset_mid_write();
        test_idle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
